memtoreg_pipe_mux: RTL and testbench

MEMTOREG_PIPE_MUX -- requirements
Module: memtoreg_pipe_mux

---
 rtl/memtoreg_pipe_mux_pkg.sv | 22 ++
 rtl/memtoreg_sel_core.sv | 28 ++
 rtl/memtoreg_pipe_mux.sv | 114 +++++++++++
 tb/tb_memtoreg_pipe_mux.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/memtoreg_pipe_mux_pkg.sv
// Shared definitions for the memtoreg select pipeline: state encoding and
// default geometry constants.
package memtoreg_pipe_mux_pkg;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_N_ENTRIES = 8;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    function automatic logic holds_result(input state_e s);
        return (s == ST_ONE) || (s == ST_FULL);
    endfunction

    function automatic logic can_accept(input state_e s);
        return (s == ST_EMPTY) || (s == ST_ONE);
    endfunction

endpackage

// File: rtl/memtoreg_sel_core.sv
// Combinational entry selection with range check; out-of-range selects
// produce zero data and raise the error flag.
module memtoreg_sel_core #(
    parameter int WIDTH     = 32,
    parameter int N_ENTRIES = 8,
    parameter int SEL_W     = $clog2(N_ENTRIES)
) (
    input  logic [N_ENTRIES*WIDTH-1:0] entries,
    input  logic [SEL_W-1:0]           sel,
    output logic [WIDTH-1:0]           sel_data,
    output logic                       sel_err
);

    int unsigned sel_idx;

    assign sel_idx = 32'(sel);
    assign sel_err = (sel_idx >= 32'(N_ENTRIES));

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < N_ENTRIES; k++) begin
            if (sel_idx == unsigned'(k)) begin
                sel_data = entries[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/memtoreg_pipe_mux.sv
// Registered select pipeline with a one-deep skid buffer so in_ready depends
// only on registered state while still sustaining one transfer per cycle.
//
// state    | meaning
// ST_EMPTY | no result held, out_valid=0
// ST_ONE   | main register holds the result on out
// ST_FULL  | main on out, skid holds the next result, in_ready=0
module memtoreg_pipe_mux
    import memtoreg_pipe_mux_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int N_ENTRIES = DEF_N_ENTRIES,
    parameter int SEL_W     = $clog2(N_ENTRIES)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_ENTRIES*WIDTH-1:0] entries,
    input  logic [SEL_W-1:0]           controlSignal,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           out,
    output logic                       out_err,
    output logic                       out_valid,
    input  logic                       out_ready
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             main_err_q, main_err_d;
    logic             skid_err_q, skid_err_d;

    logic [WIDTH-1:0] sel_data;
    logic             sel_err;
    logic             in_fire;
    logic             out_fire;

    memtoreg_sel_core #(
        .WIDTH     (WIDTH),
        .N_ENTRIES (N_ENTRIES),
        .SEL_W     (SEL_W)
    ) u_sel_core (
        .entries  (entries),
        .sel      (controlSignal),
        .sel_data (sel_data),
        .sel_err  (sel_err)
    );

    // The illegal encoding reports neither ready nor valid, so nothing is
    // accepted or emitted during the single recovery cycle.
    assign in_ready  = can_accept(state_q);
    assign out_valid = holds_result(state_q);
    assign out       = main_data_q;
    assign out_err   = main_err_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_err_d  = main_err_q;
        skid_data_d = skid_data_q;
        skid_err_d  = skid_err_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_data_d = sel_data;
                    main_err_d  = sel_err;
                    state_d     = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    main_data_d = sel_data;
                    main_err_d  = sel_err;
                end else if (in_fire) begin
                    skid_data_d = sel_data;
                    skid_err_d  = sel_err;
                    state_d     = ST_FULL;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    main_data_d = skid_data_q;
                    main_err_d  = skid_err_q;
                    state_d     = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_err_q  <= main_err_d;
            skid_data_q <= skid_data_d;
            skid_err_q  <= skid_err_d;
        end
    end

endmodule

// File: tb/tb_memtoreg_pipe_mux.sv
// Directed and randomized checks of memtoreg_pipe_mux in three geometries:
// defaults, a non-power-of-two entry count, and a narrow 4-entry variant.
module tb_memtoreg_pipe_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic [255:0] a_entries;
    logic [2:0]   a_sel;
    logic         a_in_valid, a_in_ready, a_out_err, a_out_valid, a_out_ready;
    logic [31:0]  a_out;

    logic [191:0] b_entries;
    logic [2:0]   b_sel;
    logic         b_in_valid, b_in_ready, b_out_err, b_out_valid, b_out_ready;
    logic [31:0]  b_out;

    logic [63:0]  c_entries;
    logic [1:0]   c_sel;
    logic         c_in_valid, c_in_ready, c_out_err, c_out_valid, c_out_ready;
    logic [15:0]  c_out;

    memtoreg_pipe_mux u_dut_a (
        .clk(clk), .reset(reset), .entries(a_entries), .controlSignal(a_sel),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .out(a_out),
        .out_err(a_out_err), .out_valid(a_out_valid), .out_ready(a_out_ready)
    );

    memtoreg_pipe_mux #(.WIDTH(32), .N_ENTRIES(6)) u_dut_b (
        .clk(clk), .reset(reset), .entries(b_entries), .controlSignal(b_sel),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .out(b_out),
        .out_err(b_out_err), .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

    memtoreg_pipe_mux #(.WIDTH(16), .N_ENTRIES(4)) u_dut_c (
        .clk(clk), .reset(reset), .entries(c_entries), .controlSignal(c_sel),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .out(c_out),
        .out_err(c_out_err), .out_valid(c_out_valid), .out_ready(c_out_ready)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] ent_a [8] = '{32'h0000FFFF, 32'h000001FF, 32'h0000001F, 32'h00000001,
                               32'h00000000, 32'hFFFFFFFF, 32'hF000FFFF, 32'hAAAAFFFF};
    logic [15:0] ent_c [4] = '{16'h1234, 16'hABCD, 16'h0F0F, 16'hF00D};
    logic [15:0] sb_q [$];
    int          sent = 0;
    int          recv = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 8; k++) a_entries[k*32 +: 32] = ent_a[k];
        for (int k = 0; k < 6; k++) b_entries[k*32 +: 32] = ent_a[k];
        for (int k = 0; k < 4; k++) c_entries[k*16 +: 16] = ent_c[k];
        a_sel = 3'd5; a_in_valid = 1'b1; a_out_ready = 1'b0;
        b_sel = 3'd0; b_in_valid = 1'b0; b_out_ready = 1'b0;
        c_sel = 2'd0; c_in_valid = 1'b0; c_out_ready = 1'b0;

        // Reset with a request pending: it must be discarded.
        tick(); tick();
        chk("rst_a_valid", 32'(a_out_valid), 32'd0);
        chk("rst_a_out", a_out, 32'd0);
        chk("rst_a_err", 32'(a_out_err), 32'd0);
        chk("rst_a_in_ready", 32'(a_in_ready), 32'd1);
        chk("rst_b_valid", 32'(b_out_valid), 32'd0);
        chk("rst_c_valid", 32'(c_out_valid), 32'd0);
        reset = 1'b0; a_in_valid = 1'b0;
        tick();
        chk("rst_discard", 32'(a_out_valid), 32'd0);

        // Streaming sel 0..7 with out_ready high.
        a_out_ready = 1'b1; a_in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_sel = 3'(i);
            tick();
            chk($sformatf("stream_out_%0d", i), a_out, ent_a[i]);
            chk($sformatf("stream_valid_%0d", i), 32'(a_out_valid), 32'd1);
            chk($sformatf("stream_err_%0d", i), 32'(a_out_err), 32'd0);
            chk($sformatf("stream_in_ready_%0d", i), 32'(a_in_ready), 32'd1);
        end
        a_in_valid = 1'b0;
        tick();
        chk("stream_drained", 32'(a_out_valid), 32'd0);

        // Backpressure: fill main and skid, then drain in order.
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_sel = 3'd5;
        tick();
        chk("bp_first_out", a_out, 32'hFFFFFFFF);
        chk("bp_first_valid", 32'(a_out_valid), 32'd1);
        chk("bp_first_in_ready", 32'(a_in_ready), 32'd1);
        a_sel = 3'd6;
        tick();
        chk("bp_full_out", a_out, 32'hFFFFFFFF);
        chk("bp_full_in_ready", 32'(a_in_ready), 32'd0);
        a_sel = 3'd0;
        tick();
        chk("bp_hold_out", a_out, 32'hFFFFFFFF);
        chk("bp_hold_in_ready", 32'(a_in_ready), 32'd0);
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        tick();
        chk("bp_second_out", a_out, 32'hF000FFFF);
        chk("bp_second_valid", 32'(a_out_valid), 32'd1);
        chk("bp_second_in_ready", 32'(a_in_ready), 32'd1);
        tick();
        chk("bp_empty", 32'(a_out_valid), 32'd0);

        // Reset while FULL with handshakes active.
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_sel = 3'd1;
        tick();
        a_sel = 3'd2;
        tick();
        chk("rfull_in_ready", 32'(a_in_ready), 32'd0);
        chk("rfull_out", a_out, 32'h000001FF);
        reset = 1'b1; a_sel = 3'd7; a_out_ready = 1'b1;
        tick();
        chk("rfull_valid", 32'(a_out_valid), 32'd0);
        chk("rfull_out0", a_out, 32'd0);
        chk("rfull_err0", 32'(a_out_err), 32'd0);
        chk("rfull_in_ready1", 32'(a_in_ready), 32'd1);
        reset = 1'b0; a_in_valid = 1'b0;
        tick();
        chk("rfull_no_stale_1", 32'(a_out_valid), 32'd0);
        tick();
        chk("rfull_no_stale_2", 32'(a_out_valid), 32'd0);

        // Entries change after acceptance must not affect held result.
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_sel = 3'd3;
        tick();
        chk("samp_out", a_out, 32'h00000001);
        a_in_valid = 1'b0; a_entries[3*32 +: 32] = 32'h12345678;
        tick();
        chk("samp_hold_1", a_out, 32'h00000001);
        tick();
        chk("samp_hold_2", a_out, 32'h00000001);
        a_out_ready = 1'b1;
        tick();
        chk("samp_drained", 32'(a_out_valid), 32'd0);
        a_entries[3*32 +: 32] = ent_a[3];

        // Range check with N_ENTRIES=6.
        b_out_ready = 1'b1; b_in_valid = 1'b1; b_sel = 3'd7;
        tick();
        chk("range7_out", b_out, 32'd0);
        chk("range7_err", 32'(b_out_err), 32'd1);
        chk("range7_valid", 32'(b_out_valid), 32'd1);
        b_sel = 3'd2;
        tick();
        chk("range2_out", b_out, 32'h0000001F);
        chk("range2_err", 32'(b_out_err), 32'd0);
        b_sel = 3'd6;
        tick();
        chk("range6_out", b_out, 32'd0);
        chk("range6_err", 32'(b_out_err), 32'd1);
        b_sel = 3'd5;
        tick();
        chk("range5_out", b_out, 32'hFFFFFFFF);
        chk("range5_err", 32'(b_out_err), 32'd0);
        b_in_valid = 1'b0;
        tick();
        chk("range_drained", 32'(b_out_valid), 32'd0);

        // Random handshakes against an ordered scoreboard, entries drifting.
        for (int cyc = 0; cyc < 1000; cyc++) begin
            c_in_valid  = ($urandom_range(0, 99) < 60);
            c_out_ready = ($urandom_range(0, 99) < 55);
            c_sel       = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                int idx;
                idx = int'($urandom_range(0, 3));
                ent_c[idx] = 16'($urandom);
                c_entries[idx*16 +: 16] = ent_c[idx];
            end
            chk("rnd_in_ready", 32'(c_in_ready), 32'(sb_q.size() < 2));
            chk("rnd_out_valid", 32'(c_out_valid), 32'(sb_q.size() > 0));
            if (c_out_valid && c_out_ready && sb_q.size() > 0) begin
                chk("rnd_order", 32'(c_out), 32'(sb_q[0]));
                chk("rnd_err", 32'(c_out_err), 32'd0);
                void'(sb_q.pop_front());
                recv++;
            end
            if (c_in_valid && c_in_ready) begin
                sb_q.push_back(ent_c[c_sel]);
                sent++;
            end
            tick();
        end
        c_in_valid = 1'b0; c_out_ready = 1'b1;
        for (int w = 0; w < 4; w++) begin
            if (c_out_valid && sb_q.size() > 0) begin
                chk("drain_order", 32'(c_out), 32'(sb_q[0]));
                void'(sb_q.pop_front());
                recv++;
            end
            tick();
        end
        chk("drain_empty", 32'(sb_q.size()), 32'd0);
        chk("drain_count", 32'(recv), 32'(sent));
        chk("drain_valid", 32'(c_out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
